sram_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 38 +++
 rtl/sram_ctrl_if.sv | 36 +++
 rtl/sram_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Purpose  : Shared definitions for the asynchronous SRAM controller:
//            FSM state encodings, per-board default timing, bank widths and
//            a small helper for sizing the wait-state counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  typedef logic [2:0] sram_state_t;

  localparam sram_state_t S_IDLE      = 3'd0;
  localparam sram_state_t S_WR_SETUP  = 3'd1;
  localparam sram_state_t S_WR_PULSE  = 3'd2;
  localparam sram_state_t S_WR_HOLD   = 3'd3;
  localparam sram_state_t S_RD_ACCESS = 3'd4;
  localparam sram_state_t S_RD_TURN   = 3'd5;

  // Board SRAM timing defaults (cycles)
  localparam int BASE_WR_WAIT = 2;
  localparam int BASE_RD_WAIT = 2;
  localparam int EXT_WR_WAIT  = 3;
  localparam int EXT_RD_WAIT  = 3;

  // Bank geometry
  localparam int BANK_ADDR_W = 20;
  localparam int BANK_DATA_W = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_if
// Purpose  : Request/response handshake between a bus master and sram_ctrl.
// Signals  : req_valid/req_ready  request handshake
//            req_we, req_addr, req_wdata, req_be  request payload
//            rsp_valid  one-cycle completion pulse
//            rsp_we, rsp_rdata  completion payload
// Modports : master (requester side), slave (controller side)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_we;
  logic [DATA_W-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface : sram_ctrl_if
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Single-port asynchronous SRAM controller. Accepts one word
//            request at a time, sequences CE/OE/WE/BE with configurable wait
//            states and owns the bidirectional data bus, leaving at least
//            TURN_CYCLES undriven cycles after every read.
// Ports    : clk, rst         clock, synchronous active-high reset
//            bus              request/response interface (slave side)
//            io_sram_data     SRAM data bus (driven only in write states)
//            o_sram_addr      SRAM word address
//            o_sram_be_n      byte enables, active-low
//            o_sram_ce_n/oe_n/we_n  SRAM strobes, active-low
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WR_WAIT     = 2,
  parameter int RD_WAIT     = 2,
  parameter int TURN_CYCLES = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  sram_ctrl_if.slave                bus,
  inout  wire logic [DATA_W-1:0]    io_sram_data,
  output logic      [ADDR_W-1:0]    o_sram_addr,
  output logic      [DATA_W/8-1:0]  o_sram_be_n,
  output logic                      o_sram_ce_n,
  output logic                      o_sram_oe_n,
  output logic                      o_sram_we_n
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(max3(WR_WAIT, RD_WAIT, TURN_CYCLES) + 1);

  localparam logic [CNT_W-1:0] C_WR_WAIT = CNT_W'(WR_WAIT);
  localparam logic [CNT_W-1:0] C_RD_WAIT = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] C_TURN    = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  generate
    if ((DATA_W % 8) != 0 || WR_WAIT < 1 || RD_WAIT < 1 || TURN_CYCLES < 1) begin : g_bad_params
      $error("sram_ctrl: DATA_W must be a multiple of 8 and all wait parameters >= 1");
    end
  endgenerate

  sram_state_t         r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_rdata;

  logic w_drive;
  logic w_rd_access;

  // The counter is loaded on entry to each multi-cycle state and the state
  // is left on the edge where it reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
            if (bus.req_we) begin
              r_state <= S_WR_SETUP;
            end else begin
              r_state <= S_RD_ACCESS;
              r_cnt   <= C_RD_WAIT;
            end
          end
        end
        S_WR_SETUP: begin
          r_state <= S_WR_PULSE;
          r_cnt   <= C_WR_WAIT;
        end
        S_WR_PULSE: begin
          if (r_cnt == C_ONE) begin
            r_state <= S_WR_HOLD;
            r_rdata <= '0;            // write completion reports zero data
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_WR_HOLD: begin
          r_state <= S_IDLE;
        end
        S_RD_ACCESS: begin
          if (r_cnt == C_ONE) begin
            r_rdata <= io_sram_data;
            r_state <= S_RD_TURN;
            r_cnt   <= C_TURN;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_RD_TURN: begin
          if (r_cnt == C_ONE) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded straight from the state register so that a reset
  // edge releases the bus and raises every strobe in the same cycle.
  assign w_drive     = (r_state == S_WR_SETUP) || (r_state == S_WR_PULSE) ||
                       (r_state == S_WR_HOLD);
  assign w_rd_access = (r_state == S_RD_ACCESS);

  assign io_sram_data = w_drive ? r_wdata : {DATA_W{1'bz}};
  assign o_sram_addr  = r_addr;
  assign o_sram_ce_n  = ~(w_drive | w_rd_access);
  assign o_sram_oe_n  = ~w_rd_access;
  assign o_sram_we_n  = ~(r_state == S_WR_PULSE);
  assign o_sram_be_n  = w_drive ? ~r_be : (w_rd_access ? {BE_W{1'b0}} : {BE_W{1'b1}});

  assign bus.req_ready = (r_state == S_IDLE) && !rst;
  // The counter still holds its load value only in the first turnaround cycle.
  assign bus.rsp_valid = (r_state == S_WR_HOLD) ||
                         ((r_state == S_RD_TURN) && (r_cnt == C_TURN));
  assign bus.rsp_we    = (r_state == S_WR_HOLD);
  assign bus.rsp_rdata = r_rdata;

endmodule : sram_ctrl
`default_nettype wire
